// File: rtl/ama_riscv_store_queue.sv
// rtl/ama_riscv_store_queue.sv - store align/mask stage with in-order DMEM write queue and load hazard detect
module ama_riscv_store_queue #(
   parameter int DEPTH = 2,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [AW-1:0] st_addr,
   input  logic [1:0]    st_width,
   input  logic [31:0]   st_data,
   output logic          st_misaligned,
   output logic          dmem_req,
   output logic [AW-3:0] dmem_waddr,
   output logic [3:0]    dmem_we,
   output logic [31:0]   dmem_wdata,
   input  logic          dmem_ack,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_hazard,
   output logic          empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-3:0] waddr_q [DEPTH];
   logic [3:0]    we_q    [DEPTH];
   logic [31:0]   wdata_q [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;

   logic          full;
   logic          push;
   logic          pop;
   logic          wr;
   logic          mis;
   logic [1:0]    off;
   logic [3:0]    we_enc;
   logic [31:0]   wdata_enc;
   logic [PW-1:0] idx;

   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign st_ready = !full;
   assign dmem_req = !empty;
   assign push     = st_valid && st_ready;
   assign pop      = dmem_req && dmem_ack;
   assign wr       = push && !mis;
   assign off      = st_addr[1:0];

   // Head entry is forced to zero when nothing is pending so stale storage never leaks onto the bus
   assign dmem_waddr = dmem_req ? waddr_q[head] : '0;
   assign dmem_we    = dmem_req ? we_q[head]    : '0;
   assign dmem_wdata = dmem_req ? wdata_q[head] : '0;

   // Alignment check and lane placement of the incoming store
   always_comb begin
      mis       = 1'b0;
      we_enc    = 4'b0000;
      wdata_enc = 32'h0;
      case (st_width)
         2'd0: begin
            we_enc    = 4'b0001 << off;
            wdata_enc = {24'h0, st_data[7:0]} << {off, 3'b000};
         end
         2'd1: begin
            mis       = off[0];
            we_enc    = 4'b0011 << off;
            wdata_enc = {16'h0, st_data[15:0]} << {off, 3'b000};
         end
         2'd2: begin
            mis       = (off != 2'b00);
            we_enc    = 4'b1111;
            wdata_enc = st_data;
         end
         default: mis = 1'b1;
      endcase
   end

   // Load hazard: compare against every occupied slot walking forward from head
   always_comb begin
      ld_hazard = 1'b0;
      idx       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (((PW+1)'(i) < count) && (waddr_q[idx] == ld_addr[AW-1:2]))
            ld_hazard = 1'b1;
      end
   end

   // Pointers, occupancy and the registered misalignment pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         st_misaligned <= 1'b0;
      end else begin
         st_misaligned <= push && mis;
         if (wr)
            tail <= tail + 1'b1;
         if (pop)
            head <= head + 1'b1;
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage, written at the tail on an accepted aligned store
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            waddr_q[i] <= '0;
            we_q[i]    <= '0;
            wdata_q[i] <= '0;
         end
      end else if (wr) begin
         waddr_q[tail] <= st_addr[AW-1:2];
         we_q[tail]    <= we_enc;
         wdata_q[tail] <= wdata_enc;
      end
   end

endmodule

// File: tb/tb_ama_riscv_store_queue.sv
// tb/tb_ama_riscv_store_queue.sv - scoreboard bench for ama_riscv_store_queue
module tb_ama_riscv_store_queue;

   localparam int DEPTH = 2;
   localparam int AW    = 32;

   typedef struct {
      logic [29:0] waddr;
      logic [3:0]  we;
      logic [31:0] wdata;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          st_valid;
   logic          st_ready;
   logic [AW-1:0] st_addr;
   logic [1:0]    st_width;
   logic [31:0]   st_data;
   logic          st_misaligned;
   logic          dmem_req;
   logic [AW-3:0] dmem_waddr;
   logic [3:0]    dmem_we;
   logic [31:0]   dmem_wdata;
   logic          dmem_ack;
   logic [AW-1:0] ld_addr;
   logic          ld_hazard;
   logic          empty;

   int total = 0;
   int bad   = 0;
   entry_t sb[$];

   ama_riscv_store_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_width(st_width), .st_data(st_data), .st_misaligned(st_misaligned),
      .dmem_req(dmem_req), .dmem_waddr(dmem_waddr), .dmem_we(dmem_we),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .ld_addr(ld_addr), .ld_hazard(ld_hazard), .empty(empty)
   );

   always #5 clk = ~clk;

   function automatic logic model_mis(input logic [31:0] a, input logic [1:0] w);
      return (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'b00);
   endfunction

   function automatic entry_t model_enc(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
      entry_t e;
      int n;
      int o;
      e.waddr = a[31:2];
      e.we    = 4'b0000;
      e.wdata = 32'h0;
      o = int'(a[1:0]);
      n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      for (int k = 0; k < n; k++) begin
         e.we[o+k]            = 1'b1;
         e.wdata[(o+k)*8 +: 8] = d[k*8 +: 8];
      end
      return e;
   endfunction

   // One clock of stimulus with model-based checks before and after the edge
   task automatic drive_cycle(input logic sv, input logic [31:0] a, input logic [1:0] w,
                              input logic [31:0] d, input logic ack);
      int     sz;
      logic   exp_hz;
      logic   exp_mis;
      entry_t h;
      st_valid = sv; st_addr = a; st_width = w; st_data = d; dmem_ack = ack;
      #1;
      sz = sb.size();
      total++;
      if (st_ready !== (sz < DEPTH)) begin bad++; $display("FAIL st_ready got=%0b want=%0b", st_ready, sz < DEPTH); end
      total++;
      if (empty !== (sz == 0)) begin bad++; $display("FAIL empty got=%0b want=%0b", empty, sz == 0); end
      total++;
      if (dmem_req !== (sz != 0)) begin bad++; $display("FAIL dmem_req got=%0b want=%0b", dmem_req, sz != 0); end
      exp_hz = 1'b0;
      foreach (sb[i]) if (sb[i].waddr == ld_addr[31:2]) exp_hz = 1'b1;
      total++;
      if (ld_hazard !== exp_hz) begin bad++; $display("FAIL ld_hazard got=%0b want=%0b ld_addr=%h", ld_hazard, exp_hz, ld_addr); end
      if (sz == 0) begin
         total++;
         if (dmem_we !== 4'b0 || dmem_wdata !== 32'h0)
            begin bad++; $display("FAIL idle_zero we=%b wdata=%h want 0", dmem_we, dmem_wdata); end
      end else if (ack) begin
         h = sb.pop_front();
         total++;
         if (dmem_waddr !== h.waddr || dmem_we !== h.we || dmem_wdata !== h.wdata)
            begin bad++; $display("FAIL pop_data got=%h/%b/%h want=%h/%b/%h", dmem_waddr, dmem_we, dmem_wdata, h.waddr, h.we, h.wdata); end
      end
      exp_mis = 1'b0;
      if (sv && sz < DEPTH) begin
         exp_mis = model_mis(a, w);
         if (!exp_mis) sb.push_back(model_enc(a, w, d));
      end
      @(posedge clk); #1;
      total++;
      if (st_misaligned !== exp_mis) begin bad++; $display("FAIL st_misaligned got=%0b want=%0b", st_misaligned, exp_mis); end
   endtask

   task automatic test_reset;
      rst = 1'b1; st_valid = 0; st_addr = 0; st_width = 0; st_data = 0; dmem_ack = 0; ld_addr = 0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({st_ready, st_misaligned, dmem_req, dmem_we, dmem_waddr, dmem_wdata, ld_hazard, empty} !== {1'b1, 1'b0, 1'b0, 4'b0, 30'h0, 32'h0, 1'b0, 1'b1})
         begin bad++; $display("FAIL reset_vals rdy=%b mis=%b req=%b we=%b wa=%h wd=%h hz=%b em=%b", st_ready, st_misaligned, dmem_req, dmem_we, dmem_waddr, dmem_wdata, ld_hazard, empty); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_byte;
      drive_cycle(1, 32'h1003, 2'd0, 32'h000000A5, 0);
      total++;
      if (dmem_req !== 1'b1 || dmem_waddr !== 30'h400 || dmem_we !== 4'b1000 || dmem_wdata !== 32'hA5000000)
         begin bad++; $display("FAIL byte_head req=%b wa=%h we=%b wd=%h want 1/400/1000/a5000000", dmem_req, dmem_waddr, dmem_we, dmem_wdata); end
      drive_cycle(0, 0, 0, 0, 1);
      total++;
      if (empty !== 1'b1) begin bad++; $display("FAIL byte_drain empty=%b want=1", empty); end
   endtask

   task automatic test_half_word;
      drive_cycle(1, 32'h2002, 2'd1, 32'h1234BEEF, 0);
      drive_cycle(1, 32'h2004, 2'd2, 32'hCAFEF00D, 0);
      total++;
      if (st_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", st_ready); end
      total++;
      if (dmem_we !== 4'b1100 || dmem_wdata !== 32'hBEEF0000 || dmem_waddr !== 30'h800)
         begin bad++; $display("FAIL half_head wa=%h we=%b wd=%h want 800/1100/beef0000", dmem_waddr, dmem_we, dmem_wdata); end
      drive_cycle(0, 0, 0, 0, 0);
      total++;
      if (dmem_we !== 4'b1100 || dmem_wdata !== 32'hBEEF0000)
         begin bad++; $display("FAIL half_stable we=%b wd=%h want 1100/beef0000", dmem_we, dmem_wdata); end
      drive_cycle(0, 0, 0, 0, 1);
      total++;
      if (dmem_we !== 4'b1111 || dmem_wdata !== 32'hCAFEF00D || dmem_waddr !== 30'h801)
         begin bad++; $display("FAIL word_head wa=%h we=%b wd=%h want 801/1111/cafef00d", dmem_waddr, dmem_we, dmem_wdata); end
      drive_cycle(0, 0, 0, 0, 1);
   endtask

   task automatic test_misaligned;
      drive_cycle(1, 32'h3001, 2'd2, 32'h11223344, 0);
      total++;
      if (st_misaligned !== 1'b1 || empty !== 1'b1 || dmem_req !== 1'b0)
         begin bad++; $display("FAIL mis_word mis=%b empty=%b req=%b want 1/1/0", st_misaligned, empty, dmem_req); end
      drive_cycle(1, 32'h3000, 2'd3, 32'h55667788, 0);
      total++;
      if (st_misaligned !== 1'b1 || empty !== 1'b1)
         begin bad++; $display("FAIL mis_illegal mis=%b empty=%b want 1/1", st_misaligned, empty); end
      drive_cycle(1, 32'h3003, 2'd1, 32'h0000ABCD, 0);
      drive_cycle(0, 0, 0, 0, 0);
      total++;
      if (st_misaligned !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b want=0", st_misaligned); end
   endtask

   task automatic test_hazard;
      ld_addr = 32'h1000;
      drive_cycle(1, 32'h1001, 2'd0, 32'h0000007E, 0);
      #1;
      total++;
      if (ld_hazard !== 1'b1) begin bad++; $display("FAIL hz_hit got=%b want=1", ld_hazard); end
      ld_addr = 32'h1004;
      #1;
      total++;
      if (ld_hazard !== 1'b0) begin bad++; $display("FAIL hz_miss got=%b want=0", ld_hazard); end
      ld_addr = 32'h1000;
      drive_cycle(0, 0, 0, 0, 1);
      total++;
      if (ld_hazard !== 1'b0) begin bad++; $display("FAIL hz_after_ack got=%b want=0", ld_hazard); end
      ld_addr = 32'h1000;
      drive_cycle(1, 32'h1000, 2'd2, 32'h0BADF00D, 0);
      drive_cycle(0, 0, 0, 0, 1);
   endtask

   task automatic test_back_to_back;
      logic [31:0] a;
      logic [1:0]  w;
      drive_cycle(1, 32'h4000, 2'd2, 32'hA0A0A0A0, 0);
      drive_cycle(1, 32'h4004, 2'd2, 32'hB1B1B1B1, 0);
      for (int n = 0; n < 40; n++) begin
         w = 2'($urandom_range(0, 2));
         a = 32'h4000 | 32'($urandom_range(0, 15));
         if (w == 2'd1) a[0] = 1'b0;
         if (w == 2'd2) a[1:0] = 2'b00;
         ld_addr = 32'h4000 | 32'($urandom_range(0, 15));
         drive_cycle(1, a, w, $urandom, 1);
         if (n > 1) begin
            total++;
            if (sb.size() != 1 || st_ready !== 1'b1)
               begin bad++; $display("FAIL steady_count size=%0d rdy=%b want 1/1", sb.size(), st_ready); end
         end
      end
      drive_cycle(0, 0, 0, 0, 1);
      drive_cycle(0, 0, 0, 0, 1);
      total++;
      if (empty !== 1'b1) begin bad++; $display("FAIL b2b_drain empty=%b want=1", empty); end
   endtask

   task automatic test_async_reset;
      drive_cycle(1, 32'h5000, 2'd2, 32'h12345678, 0);
      drive_cycle(1, 32'h5004, 2'd2, 32'h9ABCDEF0, 0);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (dmem_req !== 1'b0 || dmem_we !== 4'b0 || empty !== 1'b1 || st_ready !== 1'b1)
         begin bad++; $display("FAIL async_rst req=%b we=%b empty=%b rdy=%b want 0/0/1/1", dmem_req, dmem_we, empty, st_ready); end
      sb.delete();
      st_valid = 0; dmem_ack = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      drive_cycle(0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_byte();
      test_half_word();
      test_misaligned();
      test_hazard();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
